// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
// Included by the arbiter top and by its priority-decision sub-module.
package mem_arb_pkg;

  localparam int LAT_W    = 3;
  localparam int STARVE_W = 3;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } arb_owner_e;

  // Word accesses must be 16-bit aligned; an odd byte address is flagged.
  function automatic logic is_misaligned(input logic [15:0] addr);
    return addr[0];
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection: data has priority unless fetch has been
// passed over STARVE_MAX times in a row.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 3
) (
  input  logic                i_if_req,
  input  logic                i_d_req,
  input  logic [STARVE_W-1:0] i_starve_cnt,
  output arb_owner_e          o_winner
);

  // Priority decision with starvation override
  always_comb begin
    o_winner = OWN_NONE;
    case ({i_if_req, i_d_req})
      2'b10: o_winner = OWN_IF;
      2'b01: o_winner = OWN_D;
      2'b11: begin
        if (i_starve_cnt == STARVE_W'(STARVE_MAX)) begin
          o_winner = OWN_IF;
        end else begin
          o_winner = OWN_D;
        end
      end
      default: o_winner = OWN_NONE;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported 16-bit memory between instruction fetch and the
// load/store port; one access in flight, fixed MEM_LAT read latency.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_gnt,
  output logic        if_valid,
  output logic [15:0] if_rdata,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_gnt,
  output logic        d_valid,
  output logic [15:0] d_rdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        err
);

  arb_state_e          r_state;
  arb_owner_e          r_owner;
  logic [LAT_W-1:0]    r_lat_cnt;
  logic [STARVE_W-1:0] r_starve_cnt;
  logic                r_wr;

  arb_owner_e w_winner;
  logic       w_ret;
  logic       w_issue_pt;
  logic       w_gnt_if;
  logic       w_gnt_d;

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .i_if_req     (if_req),
    .i_d_req      (d_req),
    .i_starve_cnt (r_starve_cnt),
    .o_winner     (w_winner)
  );

  assign w_ret      = (r_state == ARB_WAIT) && (r_lat_cnt == LAT_W'(1));
  assign w_issue_pt = (r_state == ARB_IDLE) || w_ret;
  // Grants are gated by reset so requests cannot leak through while it is held.
  assign w_gnt_if   = rst && w_issue_pt && (w_winner == OWN_IF);
  assign w_gnt_d    = rst && w_issue_pt && (w_winner == OWN_D);

  // Memory command, grant and completion outputs
  always_comb begin
    if_gnt    = w_gnt_if;
    d_gnt     = w_gnt_d;
    mem_en    = w_gnt_if || w_gnt_d;
    mem_wr    = w_gnt_d && d_wr;
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    err       = 1'b0;
    if (w_gnt_if) begin
      mem_addr = if_addr;
      err      = is_misaligned(if_addr);
    end else if (w_gnt_d) begin
      mem_addr = d_addr;
      err      = is_misaligned(d_addr);
    end else begin
      mem_addr = 16'h0000;
      err      = 1'b0;
    end
    if (w_gnt_d && d_wr) begin
      mem_wdata = d_wdata;
    end else begin
      mem_wdata = 16'h0000;
    end
    if_valid = rst && w_ret && (r_owner == OWN_IF);
    d_valid  = rst && w_ret && (r_owner == OWN_D);
    if_rdata = if_valid ? mem_rdata : 16'h0000;
    d_rdata  = (d_valid && !r_wr) ? mem_rdata : 16'h0000;
  end

  // FSM, latency countdown and starvation counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ARB_IDLE;
      r_owner      <= OWN_NONE;
      r_lat_cnt    <= '0;
      r_starve_cnt <= '0;
      r_wr         <= 1'b0;
    end else if (w_issue_pt) begin
      if (w_winner != OWN_NONE) begin
        r_state   <= ARB_WAIT;
        r_owner   <= w_winner;
        r_lat_cnt <= LAT_W'(MEM_LAT);
        r_wr      <= (w_winner == OWN_D) && d_wr;
      end else begin
        r_state   <= ARB_IDLE;
        r_owner   <= OWN_NONE;
        r_lat_cnt <= '0;
        r_wr      <= 1'b0;
      end
      if (w_winner == OWN_IF) begin
        r_starve_cnt <= '0;
      end else if ((w_winner == OWN_D) && if_req &&
                   (r_starve_cnt != STARVE_W'(STARVE_MAX))) begin
        r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
      end else begin
        r_starve_cnt <= r_starve_cnt;
      end
    end else begin
      r_lat_cnt <= r_lat_cnt - LAT_W'(1);
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing one single-ported 16-bit memory between the instruction-fetch port and the load/store data port. Each access is issued as a one-cycle command to the memory, and read data returns a fixed `MEM_LAT` cycles later. Data accesses have priority, and a starvation counter guarantees fetch progress. The block sits between the fetch/memory stages and the `memory2c` instance and replaces fetch's hard-wired `enable=1`, `wr=0` connection.

## Interface
Parameters:
- `MEM_LAT`, default 1: cycles from issue (`mem_en`=1) to valid `mem_rdata`. Legal range 1..7.
- `STARVE_MAX`, default 3: consecutive data grants taken while fetch waits, before fetch is forced through. Legal range 1..7.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `if_req`  in  1  fetch read request; held until `if_gnt`
- `if_addr`  in  16  fetch address; stable while `if_req`=1
- `if_gnt`  out  1  one-cycle pulse in fetch's issue cycle
- `if_valid`  out  1  one-cycle pulse when `if_rdata` is valid
- `if_rdata`  out  16  read data; 0 when `if_valid`=0
- `d_req`  in  1  data request; held until `d_gnt`
- `d_wr`  in  1  1 = write, 0 = read
- `d_addr`, `d_wdata`  in  16 each  stable while `d_req`=1
- `d_gnt`  out  1  one-cycle issue pulse
- `d_valid`  out  1  one-cycle completion pulse, for reads and writes
- `d_rdata`  out  16  read data; 0 when `d_valid`=0 or for writes
- `mem_en`, `mem_wr`  out  1 each  memory command; asserted only in an issue cycle
- `mem_addr`, `mem_wdata`  out  16 each  0 outside issue cycles; `mem_wdata`=0 unless this is a data write
- `mem_rdata`  in  16  memory read data
- `err`  out  1  one-cycle pulse with a grant whose address has bit[0]=1

## Operation
- FSM states:
  - ARB_IDLE: no access in flight.
  - ARB_WAIT: one access in flight; `lat_cnt` (3 bits) counts down.
- Issue point: any ARB_IDLE cycle, or the return cycle of ARB_WAIT (`lat_cnt`==1). At the issue point, if any request is pending:
  - assert `mem_en` and the owner's `gnt`;
  - record the owner (OWN_IF or OWN_D);
  - load `lat_cnt`=`MEM_LAT`;
  - enter or stay in ARB_WAIT.
- No request pending at the issue point → go to or stay in ARB_IDLE, owner = OWN_NONE.
- In ARB_WAIT, `lat_cnt` decrements each cycle. The return cycle is `lat_cnt`==1.
  - In the return cycle, the owner's `valid` is asserted. Its `rdata` is driven combinationally from `mem_rdata` (0 for data writes).
  - A new grant may be issued in the same return cycle.
- Arbitration:
  - Only one requesting → that one wins.
  - Both requesting → data wins, unless `starve_cnt`==`STARVE_MAX`, in which case fetch wins.
- `starve_cnt`:
  - increments, saturating at `STARVE_MAX`, when data wins while `if_req`=1;
  - clears when fetch is granted;
  - otherwise holds.
- Misaligned address (bit[0]=1): the access is still performed; `err` pulses in the grant cycle.
- Requests are sampled only at issue points. A `req` deasserted before its grant is simply dropped; no error is raised.

## Timing
- Latency: grant in cycle T → `valid` in cycle T+`MEM_LAT`.
- Peak throughput: one access per `MEM_LAT` cycles. With `MEM_LAT`=1, back-to-back accesses run one per cycle.
- All outputs are combinational from state plus inputs. No output depends on `mem_rdata` except `if_rdata`/`d_rdata`.
- Reset asserted, including mid-access:
  - FSM → ARB_IDLE, owner OWN_NONE, `lat_cnt`=0, `starve_cnt`=0, immediately.
  - All outputs 0.
  - An in-flight access is abandoned: no `valid` is ever produced for it.
- First grant can occur in the first cycle after reset deasserts.

## Structure
- Package `mem_arb_pkg`:
  - state enum `ARB_IDLE`/`ARB_WAIT`;
  - owner enum `OWN_NONE`/`OWN_IF`/`OWN_D`;
  - constants `LAT_W`=3 and `STARVE_W`=3.
- Sub-module `mem_arb_pick`: combinational priority/starvation decision. Inputs: `if_req`, `d_req`, `starve_cnt`. Output: winner.
- Top level: holds the FSM, the counters, and the output muxing.

## Test plan
- `MEM_LAT`=1, `if_req` held with `if_addr`=0,2,4 in successive cycles: `if_gnt` every cycle, `if_valid` each next cycle with `if_rdata`=mem[addr], `mem_en` continuous.
- `MEM_LAT`=3, `d_req` write `d_addr`=0x0010, `d_wdata`=0xBEEF, then a read of 0x0010: `d_gnt` at T and T+3, `d_valid` at T+3 and T+6, read `d_rdata`=0xBEEF.
- `STARVE_MAX`=3, `if_req` and `d_req` both held high: grant order D,D,D,IF,D,D,D,IF; `starve_cnt` reaches 3 and then clears.
- Fetch with `if_addr`=0x0003: `err`=1 for exactly one cycle, coincident with `if_gnt`; `if_valid` still arrives `MEM_LAT` cycles later.
- `MEM_LAT`=3, `rst` asserted one cycle after a `d_gnt`: all outputs 0 immediately; no `d_valid` after release; the next request is granted in the first post-reset cycle.
- No requests for 5 cycles: FSM stays ARB_IDLE, `mem_en`=0, `mem_addr`=0, `mem_wdata`=0 throughout.
